// File: rtl/bpu_pkg.sv
// Shared types and helpers for the multi-way branch prediction unit.
package bpu_pkg;

  typedef enum logic [1:0] {
    BrCond   = 2'b00,
    BrJump   = 2'b01,
    BrCall   = 2'b10,
    BrReturn = 2'b11
  } br_type_e;

  // Tag field is sized for the widest supported tag; narrower configurations keep the
  // upper bits at zero on both the write and the compare side.
  localparam int unsigned BtbTagMax = 32;

  typedef struct packed {
    logic                 valid;
    logic [BtbTagMax-1:0] tag;
    logic [29:0]          target;
    br_type_e             br_type;
  } btb_entry_t;

  // Saturating 2-bit counter step.
  function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
    if (taken) begin
      return (ctr == 2'b11) ? ctr : ctr + 2'b01;
    end
    return (ctr == 2'b00) ? ctr : ctr - 2'b01;
  endfunction

endpackage

// File: rtl/bpu_multiway_if.sv
// Fetch/backend-facing signal bundle of the branch prediction unit.
interface bpu_multiway_if #(
  parameter int unsigned FETCH_WIDTH = 2,
  parameter int unsigned RAS_DEPTH   = 8
);
  localparam int unsigned IDXW = (FETCH_WIDTH > 1) ? $clog2(FETCH_WIDTH) : 1;
  localparam int unsigned RPW  = $clog2(RAS_DEPTH);

  logic                   next_i;
  logic                   redirect_i;
  logic [31:0]            redirect_target_i;
  logic                   update_valid_i;
  logic [31:0]            update_pc_i;
  logic                   update_taken_i;
  logic [31:0]            update_target_i;
  logic [1:0]             update_br_type_i;
  logic [1:0]             update_ctr_i;
  logic                   ras_restore_i;
  logic [RPW-1:0]         ras_ptr_i;
  logic [31:0]            pc_o;
  logic [31:0]            npc_o;
  logic [FETCH_WIDTH-1:0] valid_o;
  logic                   taken_o;
  logic [IDXW-1:0]        br_idx_o;
  logic [1:0]             br_type_o;
  logic [1:0]             ctr_o;
  logic [RPW-1:0]         ras_ptr_o;

  modport master (
    output next_i, redirect_i, redirect_target_i, update_valid_i, update_pc_i,
           update_taken_i, update_target_i, update_br_type_i, update_ctr_i,
           ras_restore_i, ras_ptr_i,
    input  pc_o, npc_o, valid_o, taken_o, br_idx_o, br_type_o, ctr_o, ras_ptr_o
  );

  modport slave (
    input  next_i, redirect_i, redirect_target_i, update_valid_i, update_pc_i,
           update_taken_i, update_target_i, update_br_type_i, update_ctr_i,
           ras_restore_i, ras_ptr_i,
    output pc_o, npc_o, valid_o, taken_o, br_idx_o, br_type_o, ctr_o, ras_ptr_o
  );
endinterface

// File: rtl/bpu_ras.sv
// Checkpointable circular return address stack; ptr addresses the top entry.
module bpu_ras
  import bpu_pkg::*;
#(
  parameter int unsigned RAS_DEPTH = 8,
  localparam int unsigned RPW = $clog2(RAS_DEPTH)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           push_i,
  input  logic           pop_i,
  input  logic [29:0]    push_addr_i,
  input  logic           restore_i,
  input  logic [RPW-1:0] restore_ptr_i,
  input  br_type_e       restore_type_i,
  input  logic [29:0]    restore_addr_i,
  output logic [29:0]    top_o,
  output logic [RPW-1:0] ptr_o
);

  logic [RPW-1:0] ptr_q, ptr_d;
  logic [29:0]    stack_q [RAS_DEPTH];
  logic           wr_en;
  logic [RPW-1:0] wr_idx;
  logic [29:0]    wr_data;

  // Next pointer and single write port; a restore overrides the speculative push/pop.
  always_comb begin
    ptr_d   = ptr_q;
    wr_en   = 1'b0;
    wr_idx  = ptr_q + RPW'(1);
    wr_data = push_addr_i;
    if (restore_i) begin
      case (restore_type_i)
        BrCall: begin
          wr_en   = 1'b1;
          wr_idx  = restore_ptr_i + RPW'(1);
          wr_data = restore_addr_i;
          ptr_d   = restore_ptr_i + RPW'(1);
        end
        BrReturn: ptr_d = restore_ptr_i - RPW'(1);
        default:  ptr_d = restore_ptr_i;
      endcase
    end else if (push_i) begin
      wr_en = 1'b1;
      ptr_d = ptr_q + RPW'(1);
    end else if (pop_i) begin
      ptr_d = ptr_q - RPW'(1);
    end
  end

  // Pointer and stack storage; wraparound overwrites the oldest entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
      for (int j = 0; j < int'(RAS_DEPTH); j++) stack_q[j] <= '0;
    end else begin
      ptr_q <= ptr_d;
      if (wr_en) stack_q[wr_idx] <= wr_data;
    end
  end

  assign top_o = stack_q[ptr_q];
  assign ptr_o = ptr_q;

endmodule

// File: rtl/bpu_multiway.sv
// Branch prediction unit: fetch PC generation plus same-cycle block prediction from
// per-lane BTB/PHT banks and a return address stack.
module bpu_multiway
  import bpu_pkg::*;
#(
  parameter int unsigned FETCH_WIDTH    = 2,
  parameter logic [31:0] RESET_PC       = 32'h1c00_0000,
  parameter int unsigned BTB_ADDR_WIDTH = 8,
  parameter int unsigned BTB_TAG_WIDTH  = 8,
  parameter int unsigned PHT_ADDR_WIDTH = 10,
  parameter int unsigned RAS_DEPTH      = 8
) (
  input logic           clk,
  input logic           rst,
  bpu_multiway_if.slave bus
);

  localparam int unsigned OFS       = $clog2(FETCH_WIDTH) + 2;
  localparam int unsigned IDXW      = (FETCH_WIDTH > 1) ? $clog2(FETCH_WIDTH) : 1;
  localparam int unsigned RPW       = $clog2(RAS_DEPTH);
  localparam int unsigned BTB_DEPTH = 2 ** BTB_ADDR_WIDTH;
  localparam int unsigned PHT_DEPTH = 2 ** PHT_ADDR_WIDTH;
  localparam logic [31:0] LaneMask  = 32'(FETCH_WIDTH - 1);
  localparam logic [31:0] TagMask   = 32'((64'd1 << BTB_TAG_WIDTH) - 64'd1);

  logic [31:0]               pc_q, pc_d;
  logic [IDXW-1:0]           start_lane, upd_lane, br_idx;
  logic [BTB_ADDR_WIDTH-1:0] btb_idx, upd_btb_idx;
  logic [PHT_ADDR_WIDTH-1:0] pht_idx, upd_pht_idx;
  logic [BtbTagMax-1:0]      tag, upd_tag;
  logic                      btb_we, pht_we;
  btb_entry_t                btb_wdata;
  btb_entry_t                rd_entry [FETCH_WIDTH];
  logic [1:0]                rd_ctr [FETCH_WIDTH];
  logic [FETCH_WIDTH-1:0]    live, pred, valid;
  btb_entry_t                sel_entry;
  logic                      taken, fire, ras_push, ras_pop;
  logic [31:0]               blk_base, ppc;
  logic [29:0]               push_word, restore_word, ras_top;
  logic [RPW-1:0]            ras_ptr;
  logic                      unused_target_lsb;

  // Decode predict-side and update-side table addresses.
  always_comb begin
    start_lane  = IDXW'((pc_q >> 2) & LaneMask);
    btb_idx     = BTB_ADDR_WIDTH'(pc_q >> OFS);
    pht_idx     = PHT_ADDR_WIDTH'(pc_q >> OFS);
    tag         = BtbTagMax'((pc_q >> (OFS + BTB_ADDR_WIDTH)) & TagMask);
    upd_lane    = IDXW'((bus.update_pc_i >> 2) & LaneMask);
    upd_btb_idx = BTB_ADDR_WIDTH'(bus.update_pc_i >> OFS);
    upd_pht_idx = PHT_ADDR_WIDTH'(bus.update_pc_i >> OFS);
    upd_tag     = BtbTagMax'((bus.update_pc_i >> (OFS + BTB_ADDR_WIDTH)) & TagMask);
    btb_we      = bus.update_valid_i & bus.update_taken_i;
    pht_we      = bus.update_valid_i & (br_type_e'(bus.update_br_type_i) == BrCond);
    btb_wdata   = '{valid: 1'b1, tag: upd_tag, target: bus.update_target_i[31:2],
                    br_type: br_type_e'(bus.update_br_type_i)};
  end

  for (genvar g = 0; g < FETCH_WIDTH; g++) begin : g_lane
    btb_entry_t btb_q [BTB_DEPTH];
    logic [1:0] pht_q [PHT_DEPTH];
    logic       hit;

    // BTB bank: cleared on reset, one synchronous write port from the update bus.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int j = 0; j < int'(BTB_DEPTH); j++) btb_q[j] <= '0;
      end else if (btb_we && upd_lane == IDXW'(g)) begin
        btb_q[upd_btb_idx] <= btb_wdata;
      end
    end

    // PHT bank: counters reset to weakly not-taken.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int j = 0; j < int'(PHT_DEPTH); j++) pht_q[j] <= 2'b01;
      end else if (pht_we && upd_lane == IDXW'(g)) begin
        pht_q[upd_pht_idx] <= ctr_next(bus.update_ctr_i, bus.update_taken_i);
      end
    end

    assign rd_entry[g] = btb_q[btb_idx];
    assign rd_ctr[g]   = pht_q[pht_idx];
    assign live[g]     = IDXW'(g) >= start_lane;
    assign hit         = rd_entry[g].valid && (rd_entry[g].tag == tag);
    assign pred[g]     = live[g] & hit & ((rd_entry[g].br_type != BrCond) | rd_ctr[g][1]);
  end

  // Pick the first predicted lane, form the next PC and the per-lane valids.
  always_comb begin
    br_idx = IDXW'(FETCH_WIDTH - 1);
    for (int i = int'(FETCH_WIDTH) - 1; i >= 0; i--) begin
      if (pred[i]) br_idx = IDXW'(i);
    end
    taken     = |pred;
    sel_entry = rd_entry[br_idx];
    blk_base  = (pc_q >> OFS) << OFS;
    if (taken && sel_entry.br_type == BrReturn) ppc = {ras_top, 2'b00};
    else if (taken)                             ppc = {sel_entry.target, 2'b00};
    else                                        ppc = blk_base + (32'd1 << OFS);
    if (bus.redirect_i)  pc_d = bus.redirect_target_i;
    else if (bus.next_i) pc_d = ppc;
    else                 pc_d = pc_q;
    fire = bus.next_i & ~bus.redirect_i;
    for (int i = 0; i < int'(FETCH_WIDTH); i++) begin
      valid[i] = fire & live[i] & (IDXW'(i) <= br_idx);
    end
    ras_push     = fire & taken & (sel_entry.br_type == BrCall);
    ras_pop      = fire & taken & (sel_entry.br_type == BrReturn);
    push_word    = (30'(blk_base >> 2) | 30'(br_idx)) + 30'd1;
    restore_word = bus.update_pc_i[31:2] + 30'd1;
  end

  // Fetch PC register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pc_q <= RESET_PC;
    else     pc_q <= pc_d;
  end

  bpu_ras #(
    .RAS_DEPTH(RAS_DEPTH)
  ) u_ras (
    .clk           (clk),
    .rst           (rst),
    .push_i        (ras_push),
    .pop_i         (ras_pop),
    .push_addr_i   (push_word),
    .restore_i     (bus.ras_restore_i),
    .restore_ptr_i (bus.ras_ptr_i),
    .restore_type_i(br_type_e'(bus.update_br_type_i)),
    .restore_addr_i(restore_word),
    .top_o         (ras_top),
    .ptr_o         (ras_ptr)
  );

  assign bus.pc_o      = pc_q;
  assign bus.npc_o     = pc_d;
  assign bus.valid_o   = valid;
  assign bus.taken_o   = taken;
  assign bus.br_idx_o  = br_idx;
  assign bus.br_type_o = sel_entry.br_type;
  assign bus.ctr_o     = rd_ctr[br_idx];
  assign bus.ras_ptr_o = ras_ptr;

  // Targets are word aligned; the low bits carry no information.
  assign unused_target_lsb = ^bus.update_target_i[1:0];

endmodule

// File: tb/tb_bpu_multiway.sv
// Directed stimulus with a queue-based scoreboard for bpu_multiway (FETCH_WIDTH=2).
module tb_bpu_multiway;
  import bpu_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bpu_multiway_if #(.FETCH_WIDTH(2), .RAS_DEPTH(8)) bus ();

  bpu_multiway #(
    .FETCH_WIDTH   (2),
    .RESET_PC      (32'h1c00_0000),
    .BTB_ADDR_WIDTH(8),
    .BTB_TAG_WIDTH (8),
    .PHT_ADDR_WIDTH(10),
    .RAS_DEPTH     (8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    string       nm;
    logic [31:0] pc;
    logic [31:0] npc;
    logic [1:0]  vld;
    logic        tk;
    logic        idx;
    int          ctr;  // -1: not checked
    int          rp;   // -1: not checked
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string nm, input string fld, input logic [31:0] act,
                     input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s.%s: got %h expected %h", nm, fld, act, req);
    end
  endtask

  // Monitor: compare the presented outputs against the oldest expectation.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      cur = exp_q.pop_front();
      chk(cur.nm, "pc", bus.pc_o, cur.pc);
      chk(cur.nm, "npc", bus.npc_o, cur.npc);
      chk(cur.nm, "valid", 32'(bus.valid_o), 32'(cur.vld));
      chk(cur.nm, "taken", 32'(bus.taken_o), 32'(cur.tk));
      chk(cur.nm, "br_idx", 32'(bus.br_idx_o), 32'(cur.idx));
      if (cur.ctr >= 0) chk(cur.nm, "ctr", 32'(bus.ctr_o), 32'(cur.ctr));
      if (cur.rp >= 0) chk(cur.nm, "ras_ptr", 32'(bus.ras_ptr_o), 32'(cur.rp));
    end
  end

  task automatic idle();
    bus.next_i            = 1'b0;
    bus.redirect_i        = 1'b0;
    bus.redirect_target_i = '0;
    bus.update_valid_i    = 1'b0;
    bus.update_pc_i       = '0;
    bus.update_taken_i    = 1'b0;
    bus.update_target_i   = '0;
    bus.update_br_type_i  = BrCond;
    bus.update_ctr_i      = 2'b00;
    bus.ras_restore_i     = 1'b0;
    bus.ras_ptr_i         = '0;
  endtask

  task automatic ex(input string nm, input logic [31:0] pc, input logic [31:0] npc,
                    input logic [1:0] vld, input logic tk, input logic idx,
                    input int ctr, input int rp);
    exp_t e;
    e.nm = nm; e.pc = pc; e.npc = npc; e.vld = vld; e.tk = tk; e.idx = idx;
    e.ctr = ctr; e.rp = rp;
    exp_q.push_back(e);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic redir(input logic [31:0] t);
    bus.redirect_i        = 1'b1;
    bus.redirect_target_i = t;
  endtask

  task automatic upd(input logic [31:0] pc, input logic [31:0] tgt, input br_type_e ty,
                     input logic tk, input logic [1:0] ctr);
    bus.update_valid_i   = 1'b1;
    bus.update_pc_i      = pc;
    bus.update_target_i  = tgt;
    bus.update_br_type_i = ty;
    bus.update_taken_i   = tk;
    bus.update_ctr_i     = ctr;
  endtask

  task automatic restore(input br_type_e ty, input logic [2:0] ptr, input logic [31:0] pc);
    bus.ras_restore_i    = 1'b1;
    bus.update_br_type_i = ty;
    bus.ras_ptr_i        = ptr;
    bus.update_pc_i      = pc;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    ex("reset", 32'h1c000000, 32'h1c000000, 2'b00, 1'b0, 1'b1, 1, 0); cyc();
    // Sequential fetch
    bus.next_i = 1'b1; ex("seq0", 32'h1c000000, 32'h1c000008, 2'b11, 1'b0, 1'b1, -1, 0); cyc();
    bus.next_i = 1'b1; ex("seq1", 32'h1c000008, 32'h1c000010, 2'b11, 1'b0, 1'b1, -1, 0); cyc();
    bus.next_i = 1'b1; ex("seq2", 32'h1c000010, 32'h1c000018, 2'b11, 1'b0, 1'b1, -1, 0); cyc();
    // Redirect into the middle of a block
    bus.next_i = 1'b1; redir(32'h1c000104);
    ex("redir", 32'h1c000018, 32'h1c000104, 2'b00, 1'b0, 1'b1, -1, 0); cyc();
    bus.next_i = 1'b1; ex("redir_blk", 32'h1c000104, 32'h1c000108, 2'b10, 1'b0, 1'b1, -1, 0);
    cyc();
    // COND at 1c000004: 01 -> 10
    upd(32'h1c000004, 32'h1c000080, BrCond, 1'b1, 2'b01);
    ex("cond_upd", 32'h1c000108, 32'h1c000108, 2'b00, 1'b0, 1'b1, -1, 0); cyc();
    redir(32'h1c000000);
    ex("to_0", 32'h1c000108, 32'h1c000000, 2'b00, 1'b0, 1'b1, -1, 0); cyc();
    // Predict taken while the counter is rewritten this cycle (old value visible)
    upd(32'h1c000004, 32'h1c000080, BrCond, 1'b0, 2'b10);
    ex("cond_tk", 32'h1c000000, 32'h1c000000, 2'b00, 1'b1, 1'b1, 2, 0); cyc();
    // Counter is now 01: not taken; saturating update 11 -> 11 issued alongside
    bus.next_i = 1'b1; upd(32'h1c000004, 32'h1c000080, BrCond, 1'b1, 2'b11);
    ex("cond_nt", 32'h1c000000, 32'h1c000008, 2'b11, 1'b0, 1'b1, 1, 0); cyc();
    bus.next_i = 1'b1; redir(32'h1c000000);
    ex("to_0b", 32'h1c000008, 32'h1c000000, 2'b00, 1'b0, 1'b1, -1, 0); cyc();
    bus.next_i = 1'b1; upd(32'h1c000000, 32'h1c000040, BrJump, 1'b1, 2'b00);
    ex("cond_sat", 32'h1c000000, 32'h1c000080, 2'b11, 1'b1, 1'b1, 3, 0); cyc();
    redir(32'h1c000000);
    ex("to_0c", 32'h1c000080, 32'h1c000000, 2'b00, 1'b0, 1'b1, -1, 0); cyc();
    // JUMP in lane 0 ends the block
    bus.next_i = 1'b1;
    ex("jump", 32'h1c000000, 32'h1c000040, 2'b01, 1'b1, 1'b0, 1, 0); cyc();
    // CALL in lane 1 of 1c000020 and RETURN at 1c000200
    upd(32'h1c000024, 32'h1c000200, BrCall, 1'b1, 2'b00);
    ex("call_upd", 32'h1c000040, 32'h1c000040, 2'b00, 1'b0, 1'b1, -1, 0); cyc();
    upd(32'h1c000200, 32'h1c000000, BrReturn, 1'b1, 2'b00); redir(32'h1c000020);
    ex("ret_upd", 32'h1c000040, 32'h1c000020, 2'b00, 1'b0, 1'b1, -1, 0); cyc();
    bus.next_i = 1'b1;
    ex("call", 32'h1c000020, 32'h1c000200, 2'b11, 1'b1, 1'b1, -1, 0); cyc();
    bus.next_i = 1'b1;
    ex("ret", 32'h1c000200, 32'h1c000028, 2'b01, 1'b1, 1'b0, -1, 1); cyc();
    // Seed stack[0] with a distinct value, then nine calls wrap over it
    restore(BrCall, 3'd7, 32'h1c000300);
    ex("seed", 32'h1c000028, 32'h1c000028, 2'b00, 1'b0, 1'b1, -1, 0); cyc();
    for (int k = 0; k < 9; k++) begin
      redir(32'h1c000020);
      ex("loop_redir", (k == 0) ? 32'h1c000028 : 32'h1c000200, 32'h1c000020, 2'b00,
         (k != 0), (k == 0), -1, k % 8);
      cyc();
      bus.next_i = 1'b1;
      ex("loop_call", 32'h1c000020, 32'h1c000200, 2'b11, 1'b1, 1'b1, -1, k % 8);
      cyc();
    end
    bus.next_i = 1'b1;
    ex("wrap_ret1", 32'h1c000200, 32'h1c000028, 2'b01, 1'b1, 1'b0, -1, 1); cyc();
    redir(32'h1c000200);
    ex("wrap_redir", 32'h1c000028, 32'h1c000200, 2'b00, 1'b0, 1'b1, -1, 0); cyc();
    bus.next_i = 1'b1;  // stack[0] was overwritten by the eighth call
    ex("wrap_ret2", 32'h1c000200, 32'h1c000028, 2'b01, 1'b1, 1'b0, -1, 0); cyc();
    // Restore beats a same-cycle push
    redir(32'h1c000020); restore(BrCall, 3'd7, 32'h1c000300);
    ex("s1", 32'h1c000028, 32'h1c000020, 2'b00, 1'b0, 1'b1, -1, 7); cyc();
    restore(BrCond, 3'd7, 32'h0);
    ex("s2", 32'h1c000020, 32'h1c000020, 2'b00, 1'b1, 1'b1, -1, 0); cyc();
    bus.next_i = 1'b1; restore(BrReturn, 3'd3, 32'h0);
    ex("push_vs_rst", 32'h1c000020, 32'h1c000200, 2'b11, 1'b1, 1'b1, -1, 7); cyc();
    restore(BrCond, 3'd0, 32'h0);
    ex("rst_ptr", 32'h1c000200, 32'h1c000200, 2'b00, 1'b1, 1'b0, -1, 2); cyc();
    bus.next_i = 1'b1;
    ex("no_push", 32'h1c000200, 32'h1c000304, 2'b01, 1'b1, 1'b0, -1, 0); cyc();
    // Asynchronous reset mid-operation
    rst = 1'b1;
    #1 ex("mid_rst", 32'h1c000000, 32'h1c000000, 2'b00, 1'b0, 1'b1, 1, 0);
    cyc();
    rst = 1'b0;
    bus.next_i = 1'b1;
    ex("post_rst", 32'h1c000000, 32'h1c000008, 2'b11, 1'b0, 1'b1, 1, 0); cyc();

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bpu_multiway.md
Name: bpu_multiway

Overview:
Parametrised next-generation branch prediction unit. It generates the fetch PC and predicts a FETCH_WIDTH-wide aligned fetch block in the same cycle. Internally it holds a tagged direct-mapped BTB, a 2-bit bimodal PHT and a checkpointable return address stack. It sits in front of the fetch/ICache stage, and the backend drives it with redirect and update traffic.

Parameters:
FETCH_WIDTH, 2, instructions per fetch block; power of 2, 1..8; OFS = log2(FETCH_WIDTH)+2
IDXW, max(1,log2(FETCH_WIDTH)), lane index width
RESET_PC, 32'h1c00_0000, PC after reset
BTB_ADDR_WIDTH, 8, BTB entries per lane bank = 2^BTB_ADDR_WIDTH
BTB_TAG_WIDTH, 8, BTB tag bits
PHT_ADDR_WIDTH, 10, PHT counters per lane bank = 2^PHT_ADDR_WIDTH
RAS_DEPTH, 8, RAS entries; power of 2; RPW = log2(RAS_DEPTH)

Ports:
clk  in  1  clock
rst  in  1  reset; one clock; reset is asynchronous and active-high
next_i  in  1  fetch accepts the current block
redirect_i  in  1  backend redirect
redirect_target_i  in  32  redirect PC
update_valid_i  in  1  resolved-branch update
update_pc_i  in  32  PC of the resolved branch
update_taken_i  in  1  actual direction
update_target_i  in  32  actual target
update_br_type_i  in  2  00 COND, 01 JUMP, 10 CALL, 11 RETURN
update_ctr_i  in  2  PHT counter snapshot taken at predict time
ras_restore_i  in  1  restore the RAS pointer
ras_ptr_i  in  RPW  RAS pointer snapshot
pc_o  out  32  current fetch PC
npc_o  out  32  next fetch PC
valid_o  out  FETCH_WIDTH  per-lane instruction valid
taken_o  out  1  block predicted taken
br_idx_o  out  IDXW  lane that ends the block
br_type_o  out  2  type of lane br_idx_o
ctr_o  out  2  PHT counter of lane br_idx_o
ras_ptr_o  out  RPW  RAS pointer before this cycle's push/pop

Behaviour:
- Reset values: pc=RESET_PC; all BTB valid bits=0; all PHT counters=2'b01; RAS ptr=0 and entries=0. With next_i=0 after reset, every output is combinational from this state: valid_o=0, taken_o=0, br_idx_o=FETCH_WIDTH-1, npc_o=RESET_PC, ras_ptr_o=0.
- Lane i address is {pc[31:OFS], i[IDXW-1:0], 2'b00}. Lane i is live when i >= pc[OFS-1:2].
- Lane i uses BTB bank i and PHT bank i. Index = pc[OFS+W-1:OFS], where W is that table's address width. BTB tag = next BTB_TAG_WIDTH bits above the index.
- Table reads are asynchronous and table writes are synchronous, so a prediction is available in the same cycle.
- A read of an entry in the cycle it is written returns the old value.
- hit_i = BTB valid & tag match. pred_i = live_i & hit_i & (type != COND | ctr_i[1]).
- br_idx_o = lowest i with pred_i set; if none, FETCH_WIDTH-1. taken_o = OR of pred_i.
- ppc:
  - taken_o & type RETURN -> {stack[ptr], 2'b00}
  - taken_o, any other type -> {btb target, 2'b00}
  - not taken -> {pc[31:OFS]+1, OFS'b0}
- npc_o = redirect_i ? redirect_target_i : next_i ? ppc : pc. pc <= npc_o every cycle.
- valid_o[i] = next_i & ~redirect_i & live_i & (i <= br_idx_o).
- RAS is a circular buffer; ptr addresses the top entry.
  - Push: when next_i & ~redirect_i & taken_o & type CALL, stack[ptr+1] <= lane address of br_idx_o + 4 and ptr <= ptr+1.
  - Pop: when the same condition holds with type RETURN, ptr <= ptr-1.
  - Overflow and underflow wrap modulo RAS_DEPTH. Overflow silently overwrites the oldest entry.
- RAS restore: when ras_restore_i, restore has priority over any push/pop this cycle.
  - update_br_type_i CALL -> stack[ras_ptr_i+1] <= update_pc_i+4 and ptr <= ras_ptr_i+1.
  - RETURN -> ptr <= ras_ptr_i-1.
  - otherwise -> ptr <= ras_ptr_i.
- BTB update: when update_valid_i & update_taken_i, write {valid=1, tag, update_target_i[31:2], update_br_type_i} into bank update_pc_i[OFS-1:2]. The write overwrites any previous entry at that index.
- PHT update: when update_valid_i & type COND, write sat(update_ctr_i ± 1) according to update_taken_i. Saturation is at 0 and 3.
- Updates are independent of redirect_i and next_i; an update and a prediction may occur in the same cycle.
- Reset asserted mid-operation clears all state asynchronously. A prediction in flight is dropped.

Decomposition:
- bpu_pkg:
  - br_type_e (COND/JUMP/CALL/RETURN)
  - btb_entry_t {valid, tag, target[31:2], type}
  - function ctr_next(ctr, taken)
- Sub-module bpu_ras (parameters RAS_DEPTH). Ports: push, pop, push_addr, restore, restore_ptr, restore_type, restore_addr, top, ptr.
- BTB and PHT are generate-loop flop arrays in the top level.

Test Plan:
- Reset, then next_i=1 with no updates -> pc_o sequence 1c000000, 1c000008, 1c000010 (FETCH_WIDTH=2); valid_o=2'b11 each cycle.
- redirect_i with target 1c000104 -> next cycle pc_o=1c000104, valid_o=2'b10; redirect cycle valid_o=0.
- Update JUMP pc=1c000000 target=1c000040 taken; later fetch 1c000000 -> taken_o=1, br_idx_o=0, valid_o=2'b01, npc_o=1c000040.
- COND at 1c000004 with update_ctr_i=01, taken=1 -> counter 10. Fetch then predicts taken, ctr_o=2'b10. Update with ctr=10, taken=0 -> 01, next fetch not taken. ctr=11 & taken=1 stays 11.
- CALL at lane 1 of 1c000020 pushes 1c000028, ras_ptr_o=0 that cycle. RETURN fetch then predicts npc_o=1c000028. Nine consecutive calls with RAS_DEPTH=8 -> ptr wraps to 1 and the oldest entry is lost.
- Push and ras_restore_i (ras_ptr_i=3, type RETURN) in the same cycle -> ptr=2 and no push written.
